// File: rtl/reg_transfer_seq.sv
// reg_transfer_seq: RegisterFile initiator for the 6502 register-transfer
// ops (TAX/TXA/TAY/TYA/TSX/TXS), JMP abs and NOP. Register-to-register moves
// go through an internal tmp register. The N/Z flags in PSR are updated with
// a read-modify-write. All rf* outputs decode from the state register and
// latched data only, so there is no combinational path from start.
module reg_transfer_seq #(
  parameter int PSR_N_BIT = 7,
  parameter int PSR_Z_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [15:0] imm16,
  input  logic [7:0]  rfDataOut,
  output logic [7:0]  rfDataIn,
  output logic [2:0]  rfRegSelect,
  output logic        rfLoad,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_TXS  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] REG_PCL = 3'd4;
  localparam logic [2:0] REG_PCH = 3'd5;
  localparam logic [2:0] REG_PSR = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_SRC = 3'd1,
    S_WR_DST = 3'd2,
    S_RD_PSR = 3'd3,
    S_WR_PSR = 3'd4,
    S_WR_PCL = 3'd5,
    S_WR_PCH = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [15:0] r_target;
  logic [7:0]  r_tmp;
  logic [7:0]  r_psr;

  // Source register of a transfer opcode (0 Acc, 1 X, 2 Y, 3 SP).
  function automatic logic [2:0] src_reg(input logic [2:0] op);
    logic [2:0] r;
    case (op)
      3'd0:    r = 3'd0;
      3'd1:    r = 3'd1;
      3'd2:    r = 3'd0;
      3'd3:    r = 3'd2;
      3'd4:    r = 3'd3;
      3'd5:    r = 3'd1;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Destination register of a transfer opcode.
  function automatic logic [2:0] dst_reg(input logic [2:0] op);
    logic [2:0] r;
    case (op)
      3'd0:    r = 3'd1;
      3'd1:    r = 3'd0;
      3'd2:    r = 3'd2;
      3'd3:    r = 3'd0;
      3'd4:    r = 3'd1;
      3'd5:    r = 3'd3;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // PSR with N and Z recomputed from the transferred value, other bits kept.
  function automatic logic [7:0] psr_update(input logic [7:0] psr, input logic [7:0] val);
    logic [7:0] r;
    r            = psr;
    r[PSR_N_BIT] = val[7];
    r[PSR_Z_BIT] = (val == 8'h00);
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; the opcode is taken straight from the input only in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (opcode < OP_JMP)       w_next = S_RD_SRC;
          else if (opcode == OP_JMP) w_next = S_WR_PCL;
          else                       w_next = S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD_SRC: w_next = S_WR_DST;
      S_WR_DST: begin
        if (r_op == OP_TXS) w_next = S_DONE;
        else                w_next = S_RD_PSR;
      end
      S_RD_PSR: w_next = S_WR_PSR;
      S_WR_PSR: w_next = S_DONE;
      S_WR_PCL: w_next = S_WR_PCH;
      S_WR_PCH: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Latch the request in IDLE and capture RegisterFile reads in the RD_* states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= 3'd0;
      r_target <= 16'h0000;
      r_tmp    <= 8'h00;
      r_psr    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= opcode;
            r_target <= imm16;
          end
        end
        S_RD_SRC: r_tmp <= rfDataOut;
        S_RD_PSR: r_psr <= rfDataOut;
        default: begin
          r_tmp <= r_tmp;
        end
      endcase
    end
  end

  // RegisterFile port and status outputs decoded from the state register.
  always_comb begin
    rfDataIn    = 8'h00;
    rfRegSelect = 3'd0;
    rfLoad      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE:   busy = 1'b0;
      S_RD_SRC: rfRegSelect = src_reg(r_op);
      S_WR_DST: begin
        rfRegSelect = dst_reg(r_op);
        rfDataIn    = r_tmp;
        rfLoad      = 1'b1;
      end
      S_RD_PSR: rfRegSelect = REG_PSR;
      S_WR_PSR: begin
        rfRegSelect = REG_PSR;
        rfDataIn    = psr_update(r_psr, r_tmp);
        rfLoad      = 1'b1;
      end
      S_WR_PCL: begin
        rfRegSelect = REG_PCL;
        rfDataIn    = r_target[7:0];
        rfLoad      = 1'b1;
      end
      S_WR_PCH: begin
        rfRegSelect = REG_PCH;
        rfDataIn    = r_target[15:8];
        rfLoad      = 1'b1;
      end
      S_DONE:   done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_reg_transfer_seq.sv
// Testbench for reg_transfer_seq: a behavioural RegisterFile plus a
// transaction-level model of the expected writes, latencies and final registers.
module tb_reg_transfer_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] imm16;
  logic [7:0]  rfDataOut;
  logic [7:0]  rfDataIn;
  logic [2:0]  rfRegSelect;
  logic        rfLoad;
  logic        busy;
  logic        done;

  logic [7:0]  rf     [0:7];
  logic [7:0]  exp_rf [0:7];
  logic        tb_we;
  logic [2:0]  tb_sel;
  logic [7:0]  tb_dat;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  reg_transfer_seq #(.PSR_N_BIT(7), .PSR_Z_BIT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .imm16       (imm16),
    .rfDataOut   (rfDataOut),
    .rfDataIn    (rfDataIn),
    .rfRegSelect (rfRegSelect),
    .rfLoad      (rfLoad),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural RegisterFile: combinational read, write on the clock edge.
  assign rfDataOut = rf[rfRegSelect];

  // RegisterFile write port, shared with the bench preload path.
  always @(posedge clk) begin
    if (rfLoad)     rf[rfRegSelect] <= rfDataIn;
    else if (tb_we) rf[tb_sel]      <= tb_dat;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack_rf();
    return {rf[7], rf[6], rf[5], rf[4], rf[3], rf[2], rf[1], rf[0]};
  endfunction

  function automatic logic [63:0] pack_exp();
    return {exp_rf[7], exp_rf[6], exp_rf[5], exp_rf[4],
            exp_rf[3], exp_rf[2], exp_rf[1], exp_rf[0]};
  endfunction

  // 6502 transfer table: TAX, TXA, TAY, TYA, TSX, TXS.
  function automatic logic [2:0] src_of(input logic [2:0] op);
    logic [2:0] t [0:5];
    t = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd1};
    return t[op];
  endfunction

  function automatic logic [2:0] dst_of(input logic [2:0] op);
    logic [2:0] t [0:5];
    t = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd3};
    return t[op];
  endfunction

  // N = bit 7, Z = bit 1 of PSR.
  function automatic logic [7:0] flags(input logic [7:0] psr, input logic [7:0] v);
    return (psr & 8'h7D) | (v[7] ? 8'h80 : 8'h00) | ((v == 8'h00) ? 8'h02 : 8'h00);
  endfunction

  task automatic preload(input logic [2:0] sel, input logic [7:0] val);
    @(negedge clk);
    tb_we  = 1'b1;
    tb_sel = sel;
    tb_dat = val;
    @(negedge clk);
    tb_we  = 1'b0;
    exp_rf[sel] = val;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] imm);
    logic [2:0] e_sel [0:1];
    logic [7:0] e_dat [0:1];
    logic [2:0] g_sel [0:3];
    logic [7:0] g_dat [0:3];
    logic [7:0] v;
    int e_n, e_done, g_n, g_done, g_busy;
    e_n = 0;
    e_done = 1;
    if (op <= 3'd5) begin
      v = exp_rf[src_of(op)];
      e_sel[0] = dst_of(op);
      e_dat[0] = v;
      exp_rf[dst_of(op)] = v;
      if (op == 3'd5) begin
        e_n = 1;
        e_done = 3;
      end else begin
        e_sel[1] = 3'd6;
        e_dat[1] = flags(exp_rf[6], v);
        exp_rf[6] = e_dat[1];
        e_n = 2;
        e_done = 5;
      end
    end else if (op == 3'd6) begin
      e_sel[0] = 3'd4; e_dat[0] = imm[7:0];
      e_sel[1] = 3'd5; e_dat[1] = imm[15:8];
      exp_rf[4] = imm[7:0];
      exp_rf[5] = imm[15:8];
      e_n = 2;
      e_done = 3;
    end
    @(negedge clk);
    start = 1'b1; opcode = op; imm16 = imm;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; opcode = 3'($urandom); imm16 = 16'($urandom);
    g_n = 0; g_done = 0; g_busy = 0;
    for (int c = 1; c <= 10 && g_done == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (busy === 1'b1) g_busy++;
      if (rfLoad === 1'b1) begin
        if (g_n < 4) begin
          g_sel[g_n] = rfRegSelect;
          g_dat[g_n] = rfDataIn;
        end
        g_n++;
      end
      if (done === 1'b1) g_done = c;
    end
    chk({tag, "_done_cycle"}, 64'(g_done), 64'(e_done));
    chk({tag, "_busy_cycles"}, 64'(g_busy), 64'(e_done));
    chk({tag, "_load_count"}, 64'(g_n), 64'(e_n));
    for (int k = 0; k < e_n && k < g_n; k++) begin
      chk({tag, "_wr_sel"}, 64'(g_sel[k]), 64'(e_sel[k]));
      chk({tag, "_wr_data"}, 64'(g_dat[k]), 64'(e_dat[k]));
    end
    @(negedge clk);
    chk({tag, "_idle_outputs"}, 64'({busy, done, rfLoad}), 64'(3'b000));
    chk({tag, "_regfile"}, pack_rf(), pack_exp());
  endtask

  initial begin
    logic [11:0] lm, bm, dm;
    reset = 1'b1; start = 1'b0; opcode = 3'd0; imm16 = 16'h0000;
    tb_we = 1'b0; tb_sel = 3'd0; tb_dat = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_rfLoad", 64'(rfLoad), 64'(1'b0));
    chk("reset_rfRegSelect", 64'(rfRegSelect), 64'(3'd0));
    chk("reset_rfDataIn", 64'(rfDataIn), 64'(8'h00));
    chk("reset_busy", 64'(busy), 64'(1'b0));
    chk("reset_done", 64'(done), 64'(1'b0));
    reset = 1'b0;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'h00);

    // TAX with a negative value.
    preload(3'd0, 8'h80); preload(3'd6, 8'h00);
    run_op("tax_neg", 3'd0, 16'h0000);
    chk("tax_neg_X", 64'(rf[1]), 64'(8'h80));
    chk("tax_neg_PSR", 64'(rf[6]), 64'(8'h80));

    // TYA with zero.
    preload(3'd2, 8'h00); preload(3'd6, 8'hFF);
    run_op("tya_zero", 3'd3, 16'h0000);
    chk("tya_zero_PSR", 64'(rf[6]), 64'(8'h7F));

    // TXS leaves flags alone; TSX updates them.
    preload(3'd1, 8'h42); preload(3'd6, 8'h35);
    run_op("txs", 3'd5, 16'h0000);
    chk("txs_SP", 64'(rf[3]), 64'(8'h42));
    chk("txs_PSR", 64'(rf[6]), 64'(8'h35));
    preload(3'd3, 8'hFF);
    run_op("tsx", 3'd4, 16'h0000);
    chk("tsx_X", 64'(rf[1]), 64'(8'hFF));
    chk("tsx_PSR", 64'(rf[6]), 64'(8'hB5));

    // JMP abs and NOP.
    run_op("jmp", 3'd6, 16'hE7B4);
    chk("jmp_PC", 64'({rf[5], rf[4]}), 64'(16'hE7B4));
    run_op("nop", 3'd7, 16'h1234);

    // start held high through a TAY: the second TAY begins only from IDLE.
    preload(3'd0, 8'h5A); preload(3'd2, 8'h00); preload(3'd6, 8'h00);
    exp_rf[2] = 8'h5A;
    exp_rf[6] = flags(8'h00, 8'h5A);
    lm = 12'h000; bm = 12'h000; dm = 12'h000;
    @(negedge clk);
    start = 1'b1; opcode = 3'd2; imm16 = 16'h0000;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      lm[c] = rfLoad;
      bm[c] = busy;
      dm[c] = done;
      if (c == 7) start = 1'b0;
    end
    @(negedge clk);
    chk("hold_load_mask", 64'(lm), 64'(12'h514));
    chk("hold_busy_mask", 64'(bm), 64'(12'hFBE));
    chk("hold_done_mask", 64'(dm), 64'(12'h820));
    chk("hold_idle_busy", 64'(busy), 64'(1'b0));
    chk("hold_regfile", pack_rf(), pack_exp());

    // Reset asserted during the WR_DST write of TXA.
    preload(3'd1, 8'h11); preload(3'd0, 8'h22);
    @(negedge clk);
    start = 1'b1; opcode = 3'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_load_before", 64'(rfLoad), 64'(1'b1));
    reset = 1'b1;
    #1;
    chk("midrst_async_load", 64'(rfLoad), 64'(1'b0));
    chk("midrst_async_busy", 64'(busy), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle_outputs",
        64'({rfLoad, busy, done, rfRegSelect, rfDataIn}), 64'(0));
    chk("midrst_regfile", pack_rf(), pack_exp());
    run_op("after_rst_txa", 3'd1, 16'h0000);

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), 8'($urandom));
      run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_transfer_seq.md
Name: reg_transfer_seq

Overview:
Register-file initiator for the 6502 core. It executes register-transfer and absolute-jump micro-operations by driving the RegisterFile write port (dataIn/regSelect/load) and reading its dataOut. Covered operations: TAX, TXA, TAY, TYA, TSX, TXS, JMP abs and NOP. It updates the N and Z flags in PSR with a read-modify-write where 6502 semantics require it. It sits between the instruction decoder (start/opcode) and RegisterFile.

Parameters:
PSR_N_BIT, 7, PSR bit index of the Negative flag
PSR_Z_BIT, 1, PSR bit index of the Zero flag

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
opcode  input  3  0 TAX, 1 TXA, 2 TAY, 3 TYA, 4 TSX, 5 TXS, 6 JMP abs, 7 NOP
imm16  input  16  jump target; sampled with start
rfDataOut  input  8  RegisterFile dataOut; combinational read of rfRegSelect
rfDataIn  output  8  drives RegisterFile dataIn
rfRegSelect  output  3  RegisterFile select (0 Acc, 1 X, 2 Y, 3 SP, 4 PCL, 5 PCH, 6 PSR)
rfLoad  output  1  RegisterFile write enable; the write occurs on the clk edge while high
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate): state=IDLE; rfLoad=0, rfRegSelect=0, rfDataIn=0, busy=0, done=0; internal tmp, psr and target regs = 0.
- IDLE: all outputs at their reset values. When start=1 at an edge, latch opcode and imm16, then branch:
  - opcodes 0-5 -> RD_SRC
  - 6 -> WR_PCL
  - 7 -> DONE
- start while busy: ignored, no queueing.
- Source/destination map: TAX 0->1, TXA 1->0, TAY 0->2, TYA 2->0, TSX 3->1, TXS 1->3.
- RD_SRC: rfRegSelect=src, rfLoad=0; tmp<=rfDataOut at the edge; -> WR_DST.
- WR_DST: rfRegSelect=dst, rfDataIn=tmp, rfLoad=1. Next state: TXS -> DONE (no flags); all others -> RD_PSR.
- RD_PSR: rfRegSelect=6, rfLoad=0; psr<=rfDataOut; -> WR_PSR.
- WR_PSR: rfRegSelect=6, rfLoad=1. rfDataIn = psr with bit PSR_N_BIT=tmp[7] and bit PSR_Z_BIT=(tmp==0); all other bits unchanged. -> DONE.
- WR_PCL: rfRegSelect=4, rfDataIn=imm16[7:0], rfLoad=1; -> WR_PCH.
- WR_PCH: rfRegSelect=5, rfDataIn=imm16[15:8], rfLoad=1; -> DONE.
- DONE: done=1, busy=1, rfLoad=0; -> IDLE. A start sampled in DONE is ignored.
- Latency, with start sampled at edge 0 and done high in cycle N:
  - flag ops (0-4): N=5
  - TXS: N=3
  - JMP: N=3
  - NOP: N=1
- Earliest next accept is the edge ending the DONE cycle + 1, i.e. start must be high in IDLE.
- rfLoad is never high for more than one consecutive register per state, and never high in IDLE, RD_* or DONE.
- Reset mid-operation: rfLoad drops immediately. Writes already committed to RegisterFile remain; an in-flight write is not completed; no done pulse.
- Outputs are registered or decoded from the state register only; there is no combinational path from start to rf*.

Test Plan:
- Flags, negative value: Acc=0x80, PSR=0x00, start TAX -> X=0x80, PSR=0x80; done in cycle 5; rfLoad high only in cycles 2 and 4.
- Flags, zero value: Y=0x00, PSR=0xFF, start TYA -> Acc=0x00, PSR=0x7F (N cleared, Z set, other bits kept); busy high cycles 1-5.
- TXS vs TSX: X=0x42, PSR=0x35, TXS -> SP=0x42, PSR still 0x35, done in cycle 3. Then TSX with SP=0xFF -> X=0xFF, PSR=0xB5.
- JMP abs: imm16=0xE7B4 -> PCL=0xB4 written in cycle 1, PCH=0xE7 in cycle 2, PC=0xE7B4, done in cycle 3. NOP -> done in cycle 1 with no rfLoad.
- Ignored start: start held high throughout a TAY -> exactly one operation is performed, then a new one is accepted only from IDLE. The second TAY copies the current Acc again; no extra loads mid-sequence.
- Mid-op reset: assert reset in WR_DST of TXA -> rfLoad=0, busy=0 asynchronously. After release, the machine is in IDLE with outputs zero and the next start behaves normally.
